seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits (legal range 1..8).
REQ-002 Parameter REFRESH_DIV, default 100000, clock cycles each digit is lit (legal range 2..2^24).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 value  input  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i, with digit 0 rightmost.
REQ-006 dp_in  input  NUM_DIGITS  decimal-point request per digit, active-high.
REQ-007 load  input  1  single-cycle strobe that captures value and dp_in into the pending register.
REQ-008 blank  input  1  while high, all anodes are off.
REQ-009 anodes  output  NUM_DIGITS  digit enables, active-low, one-hot-low when lit.
REQ-010 segments  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-011 dp  output  1  active-low decimal point of the lit digit.
REQ-012 frame_done  output  1  one-cycle pulse when digit NUM_DIGITS-1 finishes its slot.

Function
REQ-013 Encoding SHALL be, for nibble 0..F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
REQ-014 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; a wrap advances the digit index.
REQ-015 Digit index SHALL count 0..NUM_DIGITS-1 and wrap to 0; when NUM_DIGITS=1 it stays at 0.
REQ-016 load SHALL write the pending register on the same edge; a later load before a frame boundary overwrites the pending value (last write wins).
REQ-017 Display register SHALL take the pending value only at a frame boundary (the index wraps NUM_DIGITS-1 to 0), so a frame never mixes old and new nibbles.
REQ-018 If load and a frame boundary coincide, the display register SHALL take the pre-load pending value; the new value is applied at the next boundary.
REQ-019 anodes, segments and dp SHALL be registered, with 1-cycle latency from an index change to the output change.
REQ-020 frame_done SHALL be registered and high for exactly the cycle following the frame-boundary edge.
REQ-021 blank=1 SHALL force anodes to all-ones and dp to 1 on the next edge; the counters keep running, and load and frame_done keep working.
REQ-022 On anodes SHALL be exactly one bit at 0, namely bit index, unless blank is high or the digit is suppressed per REQ-027.

Reset
REQ-023 While reset is high: prescaler=0, index=0, pending=0, display=0, anodes all-ones, segments=1111111, dp=1, frame_done=0.
REQ-024 After reset deassertion, the first lit digit SHALL be digit 0, showing 1000000 (nibble 0), on the first edge.
REQ-025 Reset mid-scan SHALL discard any pending load; no partial frame resumes.

Configuration
REQ-026 The macro SEG7_LEADING_ZERO_BLANK_EN selects leading-zero suppression.
REQ-027 When the macro is defined, a digit i>0 whose display nibble is 0, and all of whose higher digits are 0, SHALL have its anode off and dp=1; digit 0 is never suppressed; a set dp_in bit on digit i or any higher digit cancels suppression for digit i and every digit below it.
REQ-028 When the macro is undefined, no digit is suppressed and no suppression logic is synthesized.

Verification (NUM_DIGITS=4, REFRESH_DIV=4)
REQ-029 Hold reset, then release; load value=16'h3A70 -> after the next frame_done, anodes cycle 1110,1101,1011,0111 with segments 1000000,1111000,0001000,0110000, each lit for 4 cycles.
REQ-030 Issue load 16'h1111 two cycles before a frame boundary, then load 16'h2222 one cycle later -> the next frame shows only 1111001 and the frame after shows only 0100100; no mixed frame occurs.
REQ-031 Issue load on the exact frame-boundary edge -> the old value is shown for one full frame, then the new value.
REQ-032 Assert blank for 10 cycles during scan -> anodes=1111 and dp=1; frame_done keeps pulsing every 16 cycles, and scan phase is unchanged after release.
REQ-033 With macro defined, value=16'h0050 and dp_in=0 -> digits 3 and 2 are dark while digits 1 and 0 are lit; with dp_in=4'b0100, digit 2 is lit as 1000000 with dp=0.
REQ-034 Assert reset asynchronously mid-digit -> all outputs reach their reset values without a clock edge, and the scan restarts at digit 0 showing 0.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: digit data/strobe inputs and registered scan outputs of the 7-segment driver.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic                    blank;
    logic [NUM_DIGITS-1:0]   anodes;
    logic [6:0]              segments;
    logic                    dp;
    logic                    frame_done;
    modport master (output value, dp_in, load, blank, input anodes, segments, dp, frame_done);
    modport slave (input value, dp_in, load, blank, output anodes, segments, dp, frame_done);
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 7-segment scan driver; new values take effect only at frame boundaries.
// Define SEG7_LEADING_ZERO_BLANK_EN to darken leading zero digits.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input logic               clk,
    input logic               reset,
    seg7_scan_driver_if.slave bus
);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int W  = 5 * NUM_DIGITS;
    localparam logic [23:0]   PRESC_MAX = 24'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    logic [23:0]             presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [W-1:0]            pend_q, pend_d, disp_q, disp_d;
    logic [NUM_DIGITS-1:0]   anodes_q, anodes_d, one_hot, supp, disp_dp;
    logic [4*NUM_DIGITS-1:0] disp_val;
    logic [6:0]              segments_q, segments_d;
    logic                    dp_q, dp_d, frame_done_q, frame_done_d;
    logic                    wrap, boundary;
    logic [3:0]              nib;
    // pending/display hold {dp bits, nibbles}
    assign {disp_dp, disp_val} = disp_q;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic zero_above;
    always_comb begin
        zero_above = 1'b1;
        supp = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above && disp_val[4*i +: 4] == 4'd0 && !disp_dp[i];
            supp[i] = zero_above;
        end
    end
`else
    assign supp = '0;
`endif
    always_comb begin
        wrap = presc_q == PRESC_MAX;
        boundary = wrap && idx_q == IDX_MAX;
        presc_d = wrap ? '0 : presc_q + 24'd1;
        idx_d = !wrap ? idx_q : (idx_q == IDX_MAX ? '0 : idx_q + 1'b1);
        pend_d = bus.load ? {bus.dp_in, bus.value} : pend_q;
        disp_d = boundary ? pend_q : disp_q;
        nib = disp_val[{idx_q, 2'b00} +: 4];
        one_hot = '0;
        one_hot[idx_q] = 1'b1;
        anodes_d = (bus.blank || supp[idx_q]) ? '1 : ~one_hot;
        segments_d = SEG[nib];
        dp_d = bus.blank || supp[idx_q] || !disp_dp[idx_q];
        frame_done_d = boundary;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q      <= '0;
            idx_q        <= '0;
            pend_q       <= '0;
            disp_q       <= '0;
            anodes_q     <= '1;
            segments_q   <= '1;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            disp_q       <= disp_d;
            anodes_q     <= anodes_d;
            segments_q   <= segments_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end
    assign bus.anodes     = anodes_q;
    assign bus.segments   = segments_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed frame-by-frame check of the scan driver (NUM_DIGITS=4, REFRESH_DIV=4).
module tb_seg7_scan_driver;
    localparam logic [31:0] RST_OUT = 32'h0000_0FFF;
    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    seg7_scan_driver_if #(.NUM_DIGITS(4)) bus ();
    seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask
    function automatic logic [31:0] outs();
        return {19'd0, bus.frame_done, bus.dp, bus.anodes, bus.segments};
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask
    task automatic drive(input logic [19:0] v);
        bus.load = 1'b1;
        {bus.dp_in, bus.value} = v;
    endtask
    // f = {dp bits, nibbles} expected on screen for the 16 cycles of one frame
    task automatic check_frame(input string tag, input logic [19:0] f, input int ld_cyc,
                               input logic [19:0] ld_a, input logic [19:0] ld_b,
                               input int bl_from, input int bl_to);
        for (int i = 0; i < 16; i++) begin
            logic bprev, off;
            int d;
            logic [3:0] nib;
            logic [31:0] exp;
            bprev = bus.blank;
            tick();
            d = ((cyc - 1) / 4) % 4;
            nib = f[4*d +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            begin
                logic z;
                z = 1'b1;
                for (int j = 3; j >= d; j--) z = z && f[4*j +: 4] == 4'd0 && !f[16+j];
                off = bprev || (d > 0 && z);
            end
`else
            off = bprev;
`endif
            exp = {19'd0, cyc % 16 == 0, off || !f[16+d], off ? 4'hF : ~(4'b0001 << d), SEG_TAB[nib]};
            chk(tag, outs(), exp);
            if (cyc == ld_cyc) drive(ld_a);
            else if (cyc == ld_cyc + 1) drive(ld_b);
            else bus.load = 1'b0;
            bus.blank = cyc >= bl_from && cyc <= bl_to;
        end
    endtask
    initial begin
        bus.value = '0;
        bus.dp_in = '0;
        bus.load  = 1'b0;
        bus.blank = 1'b0;
        #1 reset = 1'b1;
        #1 chk("reset_async", outs(), RST_OUT);
        tick();
        tick();
        chk("reset_hold", outs(), RST_OUT);
        reset = 1'b0;
        cyc = 0;
        check_frame("f0_zero", 20'h00000, 1, 20'h03A70, 20'h03A70, 0, 0);
        check_frame("f1_3a70", 20'h03A70, -10, 20'h0, 20'h0, 0, 0);
        check_frame("f2_3a70", 20'h03A70, 46, 20'h01111, 20'h02222, 0, 0);
        check_frame("f3_1111", 20'h01111, -10, 20'h0, 20'h0, 0, 0);
        check_frame("f4_2222", 20'h02222, 79, 20'h04444, 20'h04444, 0, 0);
        check_frame("f5_2222", 20'h02222, -10, 20'h0, 20'h0, 0, 0);
        check_frame("f6_4444", 20'h04444, -10, 20'h0, 20'h0, 0, 0);
        check_frame("f7_blank", 20'h04444, 125, 20'h05555, 20'h05555, 122, 131);
        check_frame("f8_blank", 20'h05555, 130, 20'h00050, 20'h00050, 122, 131);
        check_frame("f9_lz", 20'h00050, 150, 20'h40050, 20'h40050, 0, 0);
        check_frame("f10_lz_dp", 20'h40050, -10, 20'h0, 20'h0, 0, 0);
        tick();
        drive(20'h09999);
        tick();
        bus.load = 1'b0;
        #3 reset = 1'b1;
        #1 chk("reset_mid", outs(), RST_OUT);
        tick();
        reset = 1'b0;
        cyc = 0;
        check_frame("rst_f0", 20'h00000, -10, 20'h0, 20'h0, 0, 0);
        check_frame("rst_f1", 20'h00000, -10, 20'h0, 20'h0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
